icap_access_ctrl: RTL and testbench
===================================

// Module: icap_access_ctrl
// PURPOSE
//  Sole owner of the ICAPE2 port. Arbitrates N requesters (reprog trigger, status
//  readback, WBSTAR update, ...) issuing single-word config-register reads/writes.
//  Sequences ICAP word streams per transaction: dummy, sync, type-1 packet, desync.
//  ICAPE2 is instantiated one level up, clocked by clkb; all icap_* signals registered here.
// PARAMETERS
//  N_REQ     3  number of requesters (1..8)
//  READ_LAT  3  cycles with CSIB low, RDWRB high before icap_o is captured (1..15)
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high
//  req        in   N_REQ    level request; hold until gnt
//  req_wr     in   N_REQ    1=write, 0=read, per requester
//  req_addr   in   5*N_REQ  config register address, slice i = requester i
//  req_wdata  in   32*N_REQ write data, slice i = requester i
//  gnt        out  N_REQ    1-cycle pulse: request accepted, operands latched
//  done       out  N_REQ    1-cycle pulse: transaction complete, rdata valid
//  rdata      out  32       read result, held until next read completes
//  err        out  1        1-cycle pulse with done: read rejected
//  busy       out  1        high from gnt cycle through FINISH
//  icap_csib  out  1        ICAP enable, active low
//  icap_rdwrb out  1        0=write, 1=read
//  icap_i     out  32       bit-swapped ICAP data in
//  icap_o     in   32       raw ICAP data out (bit-swapped before capture)
// BEHAVIOUR
//  Reset: state IDLE, icap_csib=1, icap_rdwrb=0, icap_i=swap(FFFFFFFF), gnt=done=err=0,
//   busy=0, rdata=0, rr pointer=0. Reset mid-transaction aborts at next edge, no done.
//  Arbitration (IDLE only): round-robin from rr pointer; winner k gets gnt[k], rr -> k+1
//   (mod N_REQ). Operands latched in gnt cycle. Requests ignored while busy.
//  States, one ICAP word per cycle, CSIB=0 unless noted:
//   IDLE -> DUMMY(FFFFFFFF) -> SYNC(AA995566) -> NOOP(20000000) -> HDR
//   HDR: write 30000001|addr<<13, read 28000001|addr<<13
//   write: HDR -> DATA(wdata) -> NOOP -> DS_CMD
//   read : HDR -> NOOP -> NOOP -> RD_TURN(CSIB=1,RDWRB=1) -> RD_WAIT(CSIB=0,RDWRB=1,
//    READ_LAT cycles) -> RD_CAP(rdata<=swap(icap_o), CSIB=1) -> RD_BACK(CSIB=1,RDWRB=0) -> DS_CMD
//   DS_CMD(30008001) -> DS_VAL(0000000D) -> DS_NOOP1 -> DS_NOOP2 -> FINISH(CSIB=1, done) -> IDLE
//  Latency: write done 11 cycles after gnt cycle; read done 14+READ_LAT cycles after gnt.
//  IPROG special case: write with addr=CMD(5'h04), wdata=0000000F -> after DATA send NOOP,
//   then HALT: CSIB=1, done pulse once, busy stays 1, no further grants until reset.
//  Simultaneous req in gnt cycle of another: served in round-robin order on later IDLE.
//  icap_rdwrb changes only while icap_csib=1 (abort-free turnaround).
// CONFIGURATION
//  ICAP_READBACK_EN defined: read path as above.
//  Not defined: read states absent; a read request is granted, no ICAP activity,
//   done+err pulse 1 cycle after gnt; icap_rdwrb tied 0; rdata stays 0.
// STRUCTURE
//  Package icap_pkg: ICAP_DUMMY_WORD, ICAP_SYNC_WORD, ICAP_NO_OP, type-1 read/write
//   header bases, ICAP_DESYNC_CMD, register addrs (CMD, WBSTAR, STAT), ICAP_IPROG, state enum.
//  Sub-module icap_bitswap: combinational bit reversal within each byte; two instances
//   (icap_i out, icap_o in).
// TESTING
//  Write req0 addr=10h(WBSTAR) data=00400000 -> gnt[0]; icap_i unswapped sequence FFFFFFFF,
//   AA995566,20000000,30020001,00400000,20000000,30008001,0000000D,20000000,20000000; done[0] +11.
//  Read req1 addr=07h(STAT), model returns swap(12345678) -> header 2800E001, RDWRB rises only
//   with CSIB=1, rdata=12345678 at done[1] (+17 for READ_LAT=3); without ICAP_READBACK_EN: err+done at +1.
//  req=3'b111 held -> grants 0,1,2,0 in order; no gnt while busy.
//  Reset asserted in SYNC -> next cycle CSIB=1, RDWRB=0, state IDLE, no done.
//  Write CMD=0000000F -> ...,30008001,0000000F,20000000 then CSIB=1, done once, further req never granted.

Source files
------------

// File: rtl/icap_pkg.sv
// Shared ICAP word constants, config register addresses and controller state encoding.
// Consumers may build with ICAP_READBACK_EN to enable the readback path.
package icap_pkg;

  localparam logic [31:0] ICAP_DUMMY_WORD   = 32'hFFFF_FFFF;
  localparam logic [31:0] ICAP_SYNC_WORD    = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NO_OP        = 32'h2000_0000;
  localparam logic [31:0] ICAP_T1_WR_BASE   = 32'h3000_0001;
  localparam logic [31:0] ICAP_T1_RD_BASE   = 32'h2800_0001;
  localparam logic [31:0] ICAP_DESYNC_CMD   = 32'h3000_8001;
  localparam logic [31:0] ICAP_DESYNC_VAL   = 32'h0000_000D;
  localparam logic [31:0] ICAP_IPROG        = 32'h0000_000F;

  localparam logic [4:0]  ICAP_REG_CMD      = 5'h04;
  localparam logic [4:0]  ICAP_REG_STAT     = 5'h07;
  localparam logic [4:0]  ICAP_REG_WBSTAR   = 5'h10;

  typedef enum logic [4:0] {
    ST_IDLE, ST_DUMMY, ST_SYNC, ST_NOOP, ST_HDR, ST_DATA, ST_WR_NOOP,
    ST_RD_NOOP1, ST_RD_NOOP2, ST_RD_TURN, ST_RD_WAIT, ST_RD_CAP, ST_RD_BACK,
    ST_RD_REJ, ST_DS_CMD, ST_DS_VAL, ST_DS_NOOP1, ST_DS_NOOP2, ST_FINISH,
    ST_HALT, ST_HALTED
  } icapState_e;

  // Type-1 single-word packet header; register address sits at bits [17:13].
  function automatic logic [31:0] icapHeader(input logic wr, input logic [4:0] addr);
    return (wr ? ICAP_T1_WR_BASE : ICAP_T1_RD_BASE) | {14'b0, addr, 13'b0};
  endfunction

endpackage

// File: rtl/icap_bitswap.sv
// ICAPE2 expects each byte bit-reversed; this reverses bits within every byte.
module icap_bitswap (
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        o_data[8*b + i] = i_data[8*b + 7 - i];
      end
    end
  end

endmodule

// File: rtl/icap_access_ctrl.sv
// Round-robin arbiter and word sequencer owning the ICAPE2 port.
// Build option: ICAP_READBACK_EN enables config-register reads; otherwise reads are rejected.
module icap_access_ctrl
  import icap_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int READ_LAT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ-1:0]      i_req_wr,
  input  logic [5*N_REQ-1:0]    i_req_addr,
  input  logic [32*N_REQ-1:0]   i_req_wdata,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_done,
  output logic [31:0]           o_rdata,
  output logic                  o_err,
  output logic                  o_busy,
  output logic                  o_icap_csib,
  output logic                  o_icap_rdwrb,
  output logic [31:0]           o_icap_i,
  input  logic [31:0]           i_icap_o
);

  icapState_e        r_state, w_next;
  logic [2:0]        r_rr, r_owner, w_win, w_rrNext;
  logic [3:0]        w_idx;
  logic [7:0]        w_reqPad;
  logic              w_found, w_grant, w_finishing, w_reject, w_iprog;
  logic              r_wr, w_selWr;
  logic [4:0]        r_addr, w_selAddr;
  logic [31:0]       r_wdata, w_selWdata;
  logic [N_REQ-1:0]  r_gnt, r_done, w_gntVec, w_doneVec;
  logic              r_err, r_busy, r_csib, r_rdwrb, w_csib, w_rdwrb;
  logic [31:0]       r_rdata, r_word, w_word, w_icapOSwap;

  icap_bitswap u_swapIn  (.i_data(r_word),   .o_data(o_icap_i));
  icap_bitswap u_swapOut (.i_data(i_icap_o), .o_data(w_icapOSwap));

  assign w_reqPad = 8'(i_req);
  assign w_rrNext = (w_win == 3'(N_REQ - 1)) ? 3'd0 : w_win + 3'd1;
  assign w_iprog  = r_wr && (r_addr == ICAP_REG_CMD) && (r_wdata == ICAP_IPROG);

  // Search requesters starting at the round-robin pointer, wrapping at N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_idx = {1'b0, r_rr} + 4'(j);
      if (w_idx >= 4'(N_REQ)) w_idx = w_idx - 4'(N_REQ);
      if (!w_found && w_reqPad[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[2:0];
      end
    end
  end

  always_comb begin
    w_selWr    = 1'b0;
    w_selAddr  = '0;
    w_selWdata = '0;
    w_gntVec   = '0;
    w_doneVec  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (3'(k) == w_win) begin
        w_selWr    = i_req_wr[k];
        w_selAddr  = i_req_addr[5*k +: 5];
        w_selWdata = i_req_wdata[32*k +: 32];
        w_gntVec[k] = 1'b1;
      end
      if (3'(k) == r_owner) w_doneVec[k] = 1'b1;
    end
  end

`ifdef ICAP_READBACK_EN
  logic [3:0] r_waitCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_waitCnt <= '0;
      r_rdata   <= '0;
    end else begin
      if (r_state == ST_RD_TURN)      r_waitCnt <= '0;
      else if (r_state == ST_RD_WAIT) r_waitCnt <= r_waitCnt + 4'd1;
      if (r_state == ST_RD_CAP)       r_rdata   <= w_icapOSwap;
    end
  end

  assign w_finishing = (r_state == ST_FINISH) || (r_state == ST_HALT);
  assign w_reject    = 1'b0;
`else
  logic w_unusedIcapO;
  assign w_unusedIcapO = ^w_icapOSwap;

  always_ff @(posedge clk) begin
    r_rdata <= '0;
  end

  assign w_finishing = (r_state == ST_FINISH) || (r_state == ST_HALT) || (r_state == ST_RD_REJ);
  assign w_reject    = (r_state == ST_RD_REJ);
`endif

  // ICAP pin values are computed from the current state and registered next edge.
  always_comb begin
    w_next  = r_state;
    w_word  = ICAP_DUMMY_WORD;
    w_csib  = 1'b1;
    w_rdwrb = 1'b0;
    w_grant = 1'b0;
    case (r_state)
      ST_IDLE: if (w_found) begin
        w_grant = 1'b1;
`ifdef ICAP_READBACK_EN
        w_next  = ST_DUMMY;
`else
        w_next  = w_selWr ? ST_DUMMY : ST_RD_REJ;
`endif
      end
      ST_DUMMY:    begin w_csib = 1'b0; w_next = ST_SYNC; end
      ST_SYNC:     begin w_csib = 1'b0; w_word = ICAP_SYNC_WORD; w_next = ST_NOOP; end
      ST_NOOP:     begin w_csib = 1'b0; w_word = ICAP_NO_OP; w_next = ST_HDR; end
      ST_HDR: begin
        w_csib = 1'b0;
        w_word = icapHeader(r_wr, r_addr);
`ifdef ICAP_READBACK_EN
        w_next = r_wr ? ST_DATA : ST_RD_NOOP1;
`else
        w_next = ST_DATA;
`endif
      end
      ST_DATA:     begin w_csib = 1'b0; w_word = r_wdata; w_next = ST_WR_NOOP; end
      ST_WR_NOOP:  begin w_csib = 1'b0; w_word = ICAP_NO_OP; w_next = w_iprog ? ST_HALT : ST_DS_CMD; end
`ifdef ICAP_READBACK_EN
      ST_RD_NOOP1: begin w_csib = 1'b0; w_word = ICAP_NO_OP; w_next = ST_RD_NOOP2; end
      ST_RD_NOOP2: begin w_csib = 1'b0; w_word = ICAP_NO_OP; w_next = ST_RD_TURN; end
      ST_RD_TURN:  begin w_rdwrb = 1'b1; w_next = ST_RD_WAIT; end
      ST_RD_WAIT: begin
        w_csib  = 1'b0;
        w_rdwrb = 1'b1;
        if (r_waitCnt == 4'(READ_LAT - 1)) w_next = ST_RD_CAP;
      end
      ST_RD_CAP:   begin w_rdwrb = 1'b1; w_next = ST_RD_BACK; end
      ST_RD_BACK:  w_next = ST_DS_CMD;
`else
      ST_RD_REJ:   w_next = ST_IDLE;
`endif
      ST_DS_CMD:   begin w_csib = 1'b0; w_word = ICAP_DESYNC_CMD; w_next = ST_DS_VAL; end
      ST_DS_VAL:   begin w_csib = 1'b0; w_word = ICAP_DESYNC_VAL; w_next = ST_DS_NOOP1; end
      ST_DS_NOOP1: begin w_csib = 1'b0; w_word = ICAP_NO_OP; w_next = ST_DS_NOOP2; end
      ST_DS_NOOP2: begin w_csib = 1'b0; w_word = ICAP_NO_OP; w_next = ST_FINISH; end
      ST_FINISH:   w_next = ST_IDLE;
      ST_HALT:     w_next = ST_HALTED;
      ST_HALTED:   w_next = ST_HALTED;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rr    <= '0;
      r_owner <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_csib  <= 1'b1;
      r_rdwrb <= 1'b0;
      r_word  <= ICAP_DUMMY_WORD;
    end else begin
      r_state <= w_next;
      r_csib  <= w_csib;
      r_rdwrb <= w_rdwrb;
      r_word  <= w_word;
      r_gnt   <= w_grant ? w_gntVec : '0;
      r_done  <= w_finishing ? w_doneVec : '0;
      r_err   <= w_reject;
      r_busy  <= (w_next != ST_IDLE) || w_finishing;
      if (w_grant) begin
        r_rr    <= w_rrNext;
        r_owner <= w_win;
        r_wr    <= w_selWr;
        r_addr  <= w_selAddr;
        r_wdata <= w_selWdata;
      end
    end
  end

  assign o_gnt        = r_gnt;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_busy       = r_busy;
  assign o_rdata      = r_rdata;
  assign o_icap_csib  = r_csib;
  assign o_icap_rdwrb = r_rdwrb;

endmodule

// File: tb/tb_icap_access_ctrl.sv
// Self-checking bench for icap_access_ctrl; follows ICAP_READBACK_EN like the design.
module tb_icap_access_ctrl;

  localparam int N_REQ    = 3;
  localparam int READ_LAT = 3;
`ifdef ICAP_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req, reqWr, gnt, done;
  logic [5*N_REQ-1:0]  reqAddr;
  logic [32*N_REQ-1:0] reqWdata;
  logic [31:0]         rdata, icapI, icapO;
  logic                err, busy, csib, rdwrb;

  int nChecks = 0;
  int nFails  = 0;

  icap_access_ctrl #(.N_REQ(N_REQ), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset), .i_req(req), .i_req_wr(reqWr), .i_req_addr(reqAddr),
    .i_req_wdata(reqWdata), .o_gnt(gnt), .o_done(done), .o_rdata(rdata), .o_err(err),
    .o_busy(busy), .o_icap_csib(csib), .o_icap_rdwrb(rdwrb), .o_icap_i(icapI),
    .i_icap_o(icapO)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] swapBits(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++) r[8*b + i] = v[8*b + 7 - i];
    return r;
  endfunction

  // ICAP model: readback data only valid after READ_LAT cycles of CSIB low with RDWRB high.
  logic [31:0] modelData = '0;
  int rdRun = 0;
  always @(negedge clk) begin
    if (csib === 1'b0 && rdwrb === 1'b1) rdRun = rdRun + 1;
    else rdRun = 0;
    icapO = (rdRun >= READ_LAT) ? swapBits(modelData) : 32'hDEAD_BEEF;
  end

  typedef struct {
    int          reqIdx;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdVal;
    int          expLat;
    int          expWordCnt;
    int          expWait;
    logic        expErr;
    logic [31:0] expRdata;
    logic [31:0] expWords [10];
  } vec_t;

  function automatic vec_t mkVec(input int idx, input logic wr, input logic [4:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdVal,
                                 input logic [31:0] expRdata, input logic [31:0] hdr,
                                 input logic [31:0] word4);
    vec_t v;
    v.reqIdx = idx; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdVal = rdVal;
    v.expRdata = expRdata;
    v.expErr     = !wr && !RB;
    v.expLat     = wr ? 11 : (RB ? 14 + READ_LAT : 1);
    v.expWordCnt = (wr || RB) ? 10 : 0;
    v.expWait    = (!wr && RB) ? READ_LAT : 0;
    v.expWords = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, hdr, word4,
                   32'h20000000, 32'h30008001, 32'h0000000D, 32'h20000000, 32'h20000000};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGnt(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (gnt == '0 && cycles < 40);
    if (gnt == '0) checkOutput("gntTimeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] words[$];
    int c, doneAt, waitCyc, guardViol, extraGnt;
    logic prevRdwrb;
    req = '0;
    req[v.reqIdx] = 1'b1;
    reqWr[v.reqIdx] = v.wr;
    reqAddr[5*v.reqIdx +: 5] = v.addr;
    reqWdata[32*v.reqIdx +: 32] = v.wdata;
    modelData = v.rdVal;
    waitGnt(c);
    checkOutput("gnt", 32'(gnt), 32'(1) << v.reqIdx);
    checkOutput("busyAtGnt", 32'(busy), 32'd1);
    req = '0;
    doneAt = -1; waitCyc = 0; guardViol = 0; extraGnt = 0; prevRdwrb = rdwrb;
    for (int k = 1; k <= 40 && doneAt < 0; k++) begin
      tick();
      if (!csib && !rdwrb) words.push_back(swapBits(icapI));
      if (!csib && rdwrb) waitCyc++;
      if (rdwrb !== prevRdwrb && csib !== 1'b1) guardViol++;
      prevRdwrb = rdwrb;
      if (gnt != '0) extraGnt++;
      if (done != '0) begin
        doneAt = k;
        checkOutput("doneVec", 32'(done), 32'(1) << v.reqIdx);
        checkOutput("err", 32'(err), 32'(v.expErr));
        checkOutput("rdata", rdata, v.expRdata);
        checkOutput("csibAtDone", 32'(csib), 32'd1);
      end
    end
    checkOutput("doneLatency", doneAt, v.expLat);
    checkOutput("wordCount", words.size(), v.expWordCnt);
    for (int i = 0; i < words.size() && i < v.expWordCnt; i++)
      checkOutput($sformatf("word%0d", i), words[i], v.expWords[i]);
    checkOutput("readWaitCycles", waitCyc, v.expWait);
    checkOutput("rdwrbGuard", guardViol, 0);
    checkOutput("gntWhileBusy", extraGnt, 0);
    tick();
    checkOutput("busyAfterDone", 32'(busy), 32'd0);
    checkOutput("doneSingle", 32'(done), 32'd0);
  endtask

  vec_t vecs[4];

  initial begin
    int c, gap, lastAt, now, doneCnt, badCnt;
    logic [31:0] words[$];
    reset = 1'b1; req = '0; reqWr = '0; reqAddr = '0; reqWdata = '0;
    vecs[0] = mkVec(0, 1'b1, 5'h10, 32'h00400000, 32'h0, 32'h0, 32'h30020001, 32'h00400000);
    vecs[1] = mkVec(1, 1'b0, 5'h07, 32'h0, 32'h12345678, RB ? 32'h12345678 : 32'h0,
                    32'h2800E001, 32'h20000000);
    vecs[2] = mkVec(2, 1'b1, 5'h10, 32'hC0FFEE01, 32'h0, RB ? 32'h12345678 : 32'h0,
                    32'h30020001, 32'hC0FFEE01);
    vecs[3] = mkVec(2, 1'b0, 5'h0A, 32'h0, 32'hA5C30F96, RB ? 32'hA5C30F96 : 32'h0,
                    32'h28014001, 32'h20000000);

    repeat (3) tick();
    checkOutput("rstCsib", 32'(csib), 32'd1);
    checkOutput("rstRdwrb", 32'(rdwrb), 32'd0);
    checkOutput("rstIcapI", icapI, 32'hFFFFFFFF);
    checkOutput("rstOuts", {26'b0, gnt, done}, 32'd0);
    checkOutput("rstErrBusy", {30'b0, err, busy}, 32'd0);
    checkOutput("rstRdata", rdata, 32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset while the SYNC word is on the bus aborts without a done pulse.
    reqWr[0] = 1'b1; reqAddr[4:0] = 5'h10; reqWdata[31:0] = 32'h00400000;
    req = 3'b001;
    waitGnt(c);
    req = '0;
    tick();
    tick();
    checkOutput("syncOnBus", swapBits(icapI), 32'hAA995566);
    reset = 1'b1;
    tick();
    checkOutput("abortCsib", 32'(csib), 32'd1);
    checkOutput("abortRdwrb", 32'(rdwrb), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    reset = 1'b0;
    doneCnt = 0;
    repeat (20) begin tick(); if (done != '0) doneCnt++; end
    checkOutput("abortNoDone", doneCnt, 0);

    // All three requesters held: fair rotation, never granted while a transfer runs.
    reqWr = 3'b111;
    reqAddr = {5'h10, 5'h10, 5'h10};
    reqWdata = {32'h00000300, 32'h00000200, 32'h00000100};
    req = 3'b111;
    lastAt = 0; now = 0;
    for (int g = 0; g < 4; g++) begin
      waitGnt(c);
      now += c;
      checkOutput($sformatf("rrGnt%0d", g), 32'(gnt), 32'(1) << (g % 3));
      if (g > 0) begin
        gap = now - lastAt;
        checkOutput($sformatf("rrGap%0d", g), 32'(gap >= 12), 32'd1);
      end
      lastAt = now;
    end
    req = '0;
    c = 0;
    while (busy && c < 30) begin tick(); c++; end
    checkOutput("rrDrain", 32'(busy), 32'd0);

    // IPROG write halts the controller until reset.
    reqWr[0] = 1'b1; reqAddr[4:0] = 5'h04; reqWdata[31:0] = 32'h0000000F;
    req = 3'b001;
    waitGnt(c);
    checkOutput("iprogGnt", 32'(gnt), 32'd1);
    req = '0;
    c = -1;
    for (int k = 1; k <= 30 && c < 0; k++) begin
      tick();
      if (!csib) words.push_back(swapBits(icapI));
      if (done != '0) begin
        c = k;
        checkOutput("iprogDoneVec", 32'(done), 32'd1);
        checkOutput("iprogCsib", 32'(csib), 32'd1);
      end
    end
    checkOutput("iprogLatency", c, 7);
    checkOutput("iprogWordCount", words.size(), 6);
    if (words.size() == 6) begin
      checkOutput("iprogHdr", words[3], 32'h30008001);
      checkOutput("iprogData", words[4], 32'h0000000F);
      checkOutput("iprogNoop", words[5], 32'h20000000);
    end
    req = 3'b111;
    doneCnt = 0; badCnt = 0;
    repeat (30) begin
      tick();
      if (done != '0) doneCnt++;
      if (gnt != '0 || !busy || !csib) badCnt++;
    end
    checkOutput("haltNoDone", doneCnt, 0);
    checkOutput("haltLocked", badCnt, 0);
    req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
